display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner_pkg.sv | 26 ++
 rtl/display_scanner_tick_gen.sv | 30 +++
 rtl/display_scanner.sv | 76 +++++++
 tb/tb_display_scanner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared constants, FSM states and anode decode for the digit scanner.
// No logic of its own; pure definitions.
// No flow control.
package display_scanner_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Active-low one-hot anode pattern for one digit, or all-off if that digit is masked.
  function automatic logic [NUM_DIGITS-1:0] an_decode(
    input logic [SEL_W-1:0]      sel,
    input logic [NUM_DIGITS-1:0] mask
  );
    logic [NUM_DIGITS-1:0] r;
    r = AN_OFF;
    if (mask[sel]) r[sel] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/display_scanner_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while enabled, pulses tick on the last count.
// tick is combinational from the registered count (same cycle as count == DIV-1).
// en low freezes the count and suppresses tick; no other stall source.
module tick_gen #(
  parameter int DIV = 100000,
  localparam int W  = $clog2(DIV)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         tick,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  // Last cycle of a slot; masked during reset so no partial slot completes.
  assign tick = en && !rst && (count == LAST);

  // Free-running slot counter, held while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + W'(1);
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 8-digit anode scanner with per-slot dead time and digit mask.
// an/choice registered: new digit and blanking appear together one edge after slot_tick.
// en low freezes the scan and blanks all anodes from the next edge.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      choice,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  slot_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  // Count value on whose edge the dead time ends; zero dead time means "always past it".
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] count;
  logic          tick;
  scan_state_t   state;
  logic [SEL_W-1:0] next_choice;

  tick_gen #(.DIV(SCAN_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .tick  (tick),
    .count (count)
  );

  assign slot_tick   = tick;
  assign next_choice = choice + SEL_W'(1);

  // Scan FSM: choice, state and anode drive all update on the same edge so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_BLANK;
      choice <= '0;
      an     <= AN_OFF;
    end else if (!en) begin
      state <= ST_BLANK;
      an    <= AN_OFF;
    end else if (tick) begin
      // Slot boundary: step to the next digit; with no dead time it lights immediately.
      choice <= next_choice;
      if (BLANK_CYCLES == 0) begin
        state <= ST_SHOW;
        an    <= an_decode(next_choice, digit_mask);
      end else begin
        state <= ST_BLANK;
        an    <= AN_OFF;
      end
    end else begin
      case (state)
        ST_SHOW: begin
          an <= an_decode(choice, digit_mask);
        end
        default: begin
          // A resumed slot may already be past the dead time, so compare with >=.
          if (count >= BLANK_LAST) begin
            state <= ST_SHOW;
            an    <= an_decode(choice, digit_mask);
          end else begin
            an    <= AN_OFF;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboarded directed test of display_scanner at SCAN_DIV=4 (BLANK_CYCLES=1 and 0).
// Stimulus pushes per-cycle expectations; the monitor pops and compares at negedge.
// Also checks anode one-hot/choice consistency on both instances every cycle.
module tb_display_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mask;

  logic [2:0] choice0, choice1;
  logic [7:0] an0, an1;
  logic       tick0, tick1;

  always #5 clk = ~clk;

  display_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
    .choice(choice0), .an(an0), .slot_tick(tick0)
  );

  display_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
    .choice(choice1), .an(an1), .slot_tick(tick1)
  );

  typedef struct packed {
    logic       which;
    logic [2:0] choice;
    logic [7:0] an;
    logic       tick;
    logic [7:0] scen;
    logic [7:0] k;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   live     = 1'b0;

  // Expected outputs for the cycle following the next rising edge.
  task automatic expect_cycle(input bit which, input logic [2:0] c, input logic [7:0] a,
                              input logic t, input int scen, input int k);
    exp_t e;
    @(posedge clk);
    #1;
    e.which  = which;
    e.choice = c;
    e.an     = a;
    e.tick   = t;
    e.scen   = 8'(scen);
    e.k      = 8'(k);
    q.push_back(e);
  endtask

  task automatic do_reset(input int scen, input bit which);
    rst = 1'b1;
    expect_cycle(which, 3'd0, 8'hFF, 1'b0, scen, 0);
    rst = 1'b0;
  endtask

  // Full-mask slot pattern: dead cycle at phase 0 when blanking, digit lit otherwise.
  function automatic logic [7:0] full_an(input int k, input bit blank);
    logic [7:0] one;
    one = 8'h01 << ((k / 4) % 8);
    if (blank && (k % 4 == 0)) return 8'hFF;
    return ~one;
  endfunction

  task automatic check_onehot(input string name, input logic [7:0] a, input logic [2:0] c);
    logic [7:0] lit;
    logic [7:0] want;
    lit  = ~a;
    want = 8'h01 << c;
    n_checks++;
    if ($countones(lit) > 1 || (lit != 8'h00 && lit != want)) begin
      n_fail++;
      $display("FAIL %s onehot: an=%h choice=%0d (need at most one low bit, at choice)", name, a, c);
    end
  endtask

  // Monitor: per-cycle anode invariant on both instances, plus scoreboard pop.
  always @(negedge clk) begin
    if (live) begin
      exp_t e;
      logic [2:0] gc;
      logic [7:0] ga;
      logic       gt;
      check_onehot("dut0", an0, choice0);
      check_onehot("dut1", an1, choice1);
      if (q.size() > 0) begin
        e  = q.pop_front();
        gc = e.which ? choice1 : choice0;
        ga = e.which ? an1     : an0;
        gt = e.which ? tick1   : tick0;
        n_checks++;
        if (gc !== e.choice) begin
          n_fail++;
          $display("FAIL s%0d k%0d choice: got %0d want %0d", e.scen, e.k, gc, e.choice);
        end
        n_checks++;
        if (ga !== e.an) begin
          n_fail++;
          $display("FAIL s%0d k%0d an: got %h want %h", e.scen, e.k, ga, e.an);
        end
        n_checks++;
        if (gt !== e.tick) begin
          n_fail++;
          $display("FAIL s%0d k%0d slot_tick: got %b want %b", e.scen, e.k, gt, e.tick);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mask = 8'hFF;
    @(posedge clk);
    #1;
    live = 1'b1;

    // Scenario 1: full mask, blanking on phase 0, choice wrap 7 -> 0.
    do_reset(1, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 40; k++)
      expect_cycle(1'b0, 3'((k / 4) % 8), full_an(k, 1'b1), (k % 4) == 3, 1, k);

    // Scenario 2: only digit 2 enabled, then all digits masked while scanning.
    do_reset(2, 1'b0);
    mask = 8'h04;
    for (int k = 1; k <= 32; k++)
      expect_cycle(1'b0, 3'((k / 4) % 8),
                   ((k % 4 != 0) && ((k / 4) % 8 == 2)) ? 8'hFB : 8'hFF, (k % 4) == 3, 2, k);
    mask = 8'h00;
    for (int k = 33; k <= 40; k++)
      expect_cycle(1'b0, 3'((k / 4) % 8), 8'hFF, (k % 4) == 3, 2, k);

    // Scenario 3: drop en for 5 cycles mid-SHOW of digit 5, then resume.
    mask = 8'hFF;
    do_reset(3, 1'b0);
    for (int k = 1; k <= 21; k++)
      expect_cycle(1'b0, 3'((k / 4) % 8), full_an(k, 1'b1), (k % 4) == 3, 3, k);
    en = 1'b0;
    for (int k = 22; k <= 26; k++)
      expect_cycle(1'b0, 3'd5, 8'hFF, 1'b0, 3, k);
    en = 1'b1;
    expect_cycle(1'b0, 3'd5, 8'hDF, 1'b0, 3, 27);
    expect_cycle(1'b0, 3'd5, 8'hDF, 1'b1, 3, 28);
    expect_cycle(1'b0, 3'd6, 8'hFF, 1'b0, 3, 29);
    expect_cycle(1'b0, 3'd6, 8'hBF, 1'b0, 3, 30);
    expect_cycle(1'b0, 3'd6, 8'hBF, 1'b0, 3, 31);

    // Scenario 4: one-cycle reset while digit 6 is shown, en held high.
    rst = 1'b1;
    expect_cycle(1'b0, 3'd0, 8'hFF, 1'b0, 4, 32);
    rst = 1'b0;
    expect_cycle(1'b0, 3'd0, 8'hFE, 1'b0, 4, 33);
    expect_cycle(1'b0, 3'd0, 8'hFE, 1'b0, 4, 34);
    expect_cycle(1'b0, 3'd0, 8'hFE, 1'b1, 4, 35);
    expect_cycle(1'b0, 3'd1, 8'hFF, 1'b0, 4, 36);
    expect_cycle(1'b0, 3'd1, 8'hFD, 1'b0, 4, 37);

    // Scenario 5: zero dead time; anodes never all-off between slots, 7F -> FE at wrap.
    do_reset(5, 1'b1);
    for (int k = 1; k <= 36; k++)
      expect_cycle(1'b1, 3'((k / 4) % 8), full_an(k, 1'b0), (k % 4) == 3, 5, k);

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", q.size());
    end
    live = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
